vip_frame_ctrl: RTL and testbench

VIP_FRAME_CTRL -- requirements
Module: vip_frame_ctrl

---
 rtl/vip_frame_ctrl.sv | 165 ++++++++++++++++
 tb/tb_vip_frame_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/vip_frame_ctrl.sv
// Video frame timing controller: VSYNC/HSYNC/HREF generation with RAW pass-through.
// Define VIP_FRAME_TESTPAT_EN to replace raw_in with a built-in Bayer test pattern.
module vip_frame_ctrl #(
  parameter int IMG_HDISP = 640,
  parameter int IMG_VDISP = 480,
  parameter int H_BLANK   = 5,
  parameter int VS_W      = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic [1:0] mirror_in,
  input  logic [7:0] raw_in,
  output logic       raw_req,
  output logic       per_frame_vsync,
  output logic       per_frame_hsync,
  output logic       per_frame_href,
  output logic [7:0] per_img_RAW,
  output logic [1:0] mirror,
  output logic       busy,
  output logic       frame_done,
  output logic [15:0] frame_cnt
);

  localparam logic [13:0] H_LAST     = 14'(IMG_HDISP + H_BLANK - 1);
  localparam logic [13:0] V_LAST     = 14'(IMG_VDISP - 1);
  localparam logic [13:0] VS_LAST    = 14'(VS_W - 1);
  localparam logic [13:0] HREF_FIRST = 14'd2;
  localparam logic [13:0] HREF_LAST  = 14'(IMG_HDISP + 1);
  localparam logic [13:0] REQ_LAST   = 14'(IMG_HDISP);

  typedef enum logic [1:0] {IDLE, VSYNC, LINE} state_t;

  state_t      state_q, state_d;
  logic [13:0] h_q, h_d;
  logic [13:0] line_q, line_d;
  logic        stop_pend_q, stop_pend_d;

  logic        vsync_q, vsync_d;
  logic        hsync_q, hsync_d;
  logic        href_q, href_d;
  logic [7:0]  raw_q, raw_d;
  logic [1:0]  mirror_q, mirror_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [15:0] cnt_q, cnt_d;
  logic        last_d;
  logic [7:0]  pix_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      h_q         <= '0;
      line_q      <= '0;
      stop_pend_q <= 1'b0;
      vsync_q     <= 1'b1;
      hsync_q     <= 1'b1;
      href_q      <= 1'b0;
      raw_q       <= '0;
      mirror_q    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      h_q         <= h_d;
      line_q      <= line_d;
      stop_pend_q <= stop_pend_d;
      vsync_q     <= vsync_d;
      hsync_q     <= hsync_d;
      href_q      <= href_d;
      raw_q       <= raw_d;
      mirror_q    <= mirror_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      cnt_q       <= cnt_d;
    end
  end

  // The VSYNC phase reuses the h counter to time the sync pulse width.
  always_comb begin
    state_d     = state_q;
    h_d         = h_q;
    line_d      = line_q;
    stop_pend_d = stop_pend_q;
    case (state_q)
      IDLE: begin
        stop_pend_d = 1'b0;
        if (start && !stop) begin
          state_d = VSYNC;
          h_d     = '0;
          line_d  = '0;
        end
      end
      VSYNC: begin
        if (stop) stop_pend_d = 1'b1;
        if (h_q == VS_LAST) begin
          state_d = LINE;
          h_d     = '0;
          line_d  = '0;
        end else begin
          h_d = h_q + 14'd1;
        end
      end
      LINE: begin
        if (stop) stop_pend_d = 1'b1;
        if (h_q == H_LAST) begin
          h_d = '0;
          if (line_q == V_LAST) begin
            line_d = '0;
            if (stop_pend_q || stop) begin
              state_d     = IDLE;
              stop_pend_d = 1'b0;
            end else begin
              state_d = VSYNC;
            end
          end else begin
            line_d = line_q + 14'd1;
          end
        end else begin
          h_d = h_q + 14'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so each register lines up with its state cycle.
  always_comb begin
    last_d   = (state_d == LINE) && (h_d == H_LAST) && (line_d == V_LAST);
    vsync_d  = (state_d != VSYNC);
    hsync_d  = !((state_d == VSYNC) || ((state_d == LINE) && (h_d < HREF_FIRST)));
    href_d   = (state_d == LINE) && (h_d >= HREF_FIRST) && (h_d <= HREF_LAST);
    busy_d   = (state_d != IDLE);
    done_d   = last_d;
    cnt_d    = last_d ? cnt_q + 16'd1 : cnt_q;
    mirror_d = ((state_d == VSYNC) && (state_q != VSYNC)) ? mirror_in : mirror_q;
`ifdef VIP_FRAME_TESTPAT_EN
    // pixel_index = h-2 has the same parity as h
    case ({line_d[0], h_d[0]})
      2'b00:   pix_d = 8'd100;
      2'b01:   pix_d = 8'd150;
      2'b10:   pix_d = 8'd150;
      default: pix_d = 8'd200;
    endcase
`else
    pix_d = raw_in;
`endif
    raw_d = href_d ? pix_d : 8'd0;
  end

  // Request leads href by one cycle; derived from registered state only.
  assign raw_req = (state_q == LINE) && (h_q >= 14'd1) && (h_q <= REQ_LAST);

  assign per_frame_vsync = vsync_q;
  assign per_frame_hsync = hsync_q;
  assign per_frame_href  = href_q;
  assign per_img_RAW     = raw_q;
  assign mirror          = mirror_q;
  assign busy            = busy_q;
  assign frame_done      = done_q;
  assign frame_cnt       = cnt_q;

endmodule

// File: tb/tb_vip_frame_ctrl.sv
// Scoreboard bench for vip_frame_ctrl: frame-level reference model feeds a per-cycle expectation queue.
module tb_vip_frame_ctrl;
  localparam int HD  = 8;
  localparam int VD  = 4;
  localparam int HB  = 5;
  localparam int VSW = 4;
  localparam int HT  = HD + HB;

  logic        clk = 1'b0;
  logic        rst, start, stop;
  logic [1:0]  mirror_in;
  logic [7:0]  raw_in;
  logic        raw_req, per_frame_vsync, per_frame_hsync, per_frame_href;
  logic [7:0]  per_img_RAW;
  logic [1:0]  mirror;
  logic        busy, frame_done;
  logic [15:0] frame_cnt;

  always #5 clk = ~clk;

  vip_frame_ctrl #(.IMG_HDISP(HD), .IMG_VDISP(VD), .H_BLANK(HB), .VS_W(VSW)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .mirror_in(mirror_in),
    .raw_in(raw_in), .raw_req(raw_req), .per_frame_vsync(per_frame_vsync),
    .per_frame_hsync(per_frame_hsync), .per_frame_href(per_frame_href),
    .per_img_RAW(per_img_RAW), .mirror(mirror), .busy(busy),
    .frame_done(frame_done), .frame_cnt(frame_cnt)
  );

  typedef struct {
    logic        vs, hs, href, busy, done;
    logic [15:0] cnt;
    logic [1:0]  mir;
    int          ln, px;
  } rec_t;

  rec_t        exp_q[$];
  logic [7:0]  pix_q[$];
  int          checks = 0;
  int          errors = 0;
  bit          mon_en = 1'b0;
  bit          pending = 1'b0;
  logic [15:0] m_cnt = 16'd0;
  logic [1:0]  m_mir = 2'd0;

  function automatic rec_t idle_rec();
    rec_t r;
    r.vs = 1'b1; r.hs = 1'b1; r.href = 1'b0; r.busy = 1'b0; r.done = 1'b0;
    r.cnt = m_cnt; r.mir = m_mir; r.ln = 0; r.px = 0;
    return r;
  endfunction

  function automatic logic [7:0] pat(input int ln, input int px);
    int k;
    k = (ln % 2) * 2 + (px % 2);
    case (k)
      0:       return 8'd100;
      1:       return 8'd150;
      2:       return 8'd150;
      default: return 8'd200;
    endcase
  endfunction

  // One whole frame of expected output, one record per clock.
  task automatic push_frame(input logic [1:0] m);
    rec_t r;
    bit   last;
    for (int i = 0; i < VSW; i++) begin
      r.vs = 1'b0; r.hs = 1'b0; r.href = 1'b0; r.busy = 1'b1; r.done = 1'b0;
      r.cnt = m_cnt; r.mir = m; r.ln = 0; r.px = 0;
      exp_q.push_back(r);
    end
    for (int l = 0; l < VD; l++) begin
      for (int h = 0; h < HT; h++) begin
        last = (l == VD - 1) && (h == HT - 1);
        r.vs = 1'b1; r.hs = (h >= 2); r.href = (h >= 2) && (h <= HD + 1);
        r.busy = 1'b1; r.done = last;
        r.cnt = last ? m_cnt + 16'd1 : m_cnt;
        r.mir = m; r.ln = l; r.px = h - 2;
        exp_q.push_back(r);
      end
    end
    m_cnt = m_cnt + 16'd1;
    m_mir = m;
  endtask

  task automatic cyc(input bit st, input bit sp, input logic [1:0] mi, input bit r);
    @(posedge clk);
    #1;
    rst = r; start = st; stop = sp; mirror_in = mi; raw_in = 8'($urandom);
    if (!r) begin
      if (sp && exp_q.size() > 0) pending = 1'b1;
      if (st && !sp && exp_q.size() == 0) begin
        exp_q.push_back(idle_rec());
        push_frame(mi);
      end else if (exp_q.size() == 1) begin
        if (pending) pending = 1'b0;
        else push_frame(mi);
      end
      if (exp_q.size() > 1 && exp_q[1].href) begin
`ifdef VIP_FRAME_TESTPAT_EN
        pix_q.push_back(pat(exp_q[1].ln, exp_q[1].px));
`else
        pix_q.push_back(raw_in);
`endif
      end
    end
  endtask

  task automatic check_reset(input string name);
    checks++;
    if ({per_frame_vsync, per_frame_hsync, per_frame_href, per_img_RAW, mirror,
         busy, frame_done, frame_cnt, raw_req} !== {1'b1, 1'b1, 1'b0, 8'd0, 2'd0,
         1'b0, 1'b0, 16'd0, 1'b0}) begin
      errors++;
      $display("FAIL %s: got vs=%b hs=%b href=%b raw=%0d mir=%b busy=%b done=%b cnt=%0d req=%b, want idle reset values",
               name, per_frame_vsync, per_frame_hsync, per_frame_href, per_img_RAW,
               mirror, busy, frame_done, frame_cnt, raw_req);
    end
  endtask

  // Monitor: pops one expectation per clock; empty queue means the controller should be idle.
  always @(negedge clk) begin
    rec_t       e;
    logic [7:0] ex_raw;
    logic       ex_req;
    if (mon_en) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : idle_rec();
      ex_raw = 8'd0;
      if (e.href && pix_q.size() > 0) ex_raw = pix_q.pop_front();
      ex_req = (exp_q.size() > 0) ? exp_q[0].href : 1'b0;
      checks++;
      if ({per_frame_vsync, per_frame_hsync, per_frame_href, busy, frame_done,
           frame_cnt, mirror, per_img_RAW, raw_req} !==
          {e.vs, e.hs, e.href, e.busy, e.done, e.cnt, e.mir, ex_raw, ex_req}) begin
        errors++;
        $display("FAIL cycle@%0t: got vs=%b hs=%b href=%b busy=%b done=%b cnt=%0d mir=%b raw=%0d req=%b; want vs=%b hs=%b href=%b busy=%b done=%b cnt=%0d mir=%b raw=%0d req=%b",
                 $time, per_frame_vsync, per_frame_hsync, per_frame_href, busy, frame_done,
                 frame_cnt, mirror, per_img_RAW, raw_req, e.vs, e.hs, e.href, e.busy,
                 e.done, e.cnt, e.mir, ex_raw, ex_req);
      end
    end
  end

  initial begin
    logic [1:0] mi;
    rst = 1'b1; start = 1'b0; stop = 1'b0; mirror_in = 2'd0; raw_in = 8'd0;
    #1;
    check_reset("reset_init");
    repeat (3) cyc(1'b0, 1'b0, 2'd0, 1'b1);
    cyc(1'b0, 1'b0, 2'd0, 1'b0);
    mon_en = 1'b1;

    // stop while idle, then frame 1 with mirror 01, mirror changes mid-frame, start while busy
    repeat (4) cyc(1'b0, 1'b1, 2'd0, 1'b0);
    cyc(1'b1, 1'b0, 2'b01, 1'b0);
    repeat (20) cyc(1'b0, 1'b0, 2'b01, 1'b0);
    cyc(1'b1, 1'b0, 2'b10, 1'b0);
    repeat (55) cyc(1'b0, 1'b0, 2'b10, 1'b0);
    // frame 2 runs back-to-back; stop during its line 1
    cyc(1'b0, 1'b1, 2'b10, 1'b0);
    repeat (60) cyc(1'b0, 1'b0, 2'b11, 1'b0);
    // start together with stop in idle is ignored
    cyc(1'b1, 1'b1, 2'b11, 1'b0);
    repeat (5) cyc(1'b0, 1'b0, 2'b11, 1'b0);

    // randomized control traffic
    mi = 2'd0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 15) == 0) mi = 2'($urandom);
      cyc($urandom_range(0, 24) == 0, $urandom_range(0, 59) == 0, mi, 1'b0);
    end
    for (int k = 0; k < 300 && exp_q.size() > 0; k++) cyc(1'b0, 1'b1, mi, 1'b0);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d records left, want 0", exp_q.size());
    end
    repeat (3) cyc(1'b0, 1'b0, mi, 1'b0);

    // asynchronous reset in the middle of line 2
    cyc(1'b1, 1'b0, 2'b11, 1'b0);
    repeat (VSW + 2 * HT + 5) cyc(1'b0, 1'b0, 2'b11, 1'b0);
    #2;
    mon_en = 1'b0;
    rst = 1'b1;
    #1;
    check_reset("reset_midframe");
    exp_q.delete(); pix_q.delete();
    pending = 1'b0; m_cnt = 16'd0; m_mir = 2'd0;
    repeat (3) cyc(1'b1, 1'b0, 2'b11, 1'b1);
    check_reset("start_during_reset");
    cyc(1'b0, 1'b0, 2'b11, 1'b0);
    mon_en = 1'b1;
    repeat (3) cyc(1'b0, 1'b0, 2'b11, 1'b0);
    cyc(1'b1, 1'b0, 2'b10, 1'b0);
    repeat (10) cyc(1'b0, 1'b0, 2'b10, 1'b0);
    cyc(1'b0, 1'b1, 2'b10, 1'b0);
    repeat (60) cyc(1'b0, 1'b0, 2'b10, 1'b0);
    checks++;
    if (frame_cnt !== 16'd1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_frame: got frame_cnt=%0d busy=%b, want frame_cnt=1 busy=0",
               frame_cnt, busy);
    end
    mon_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
